cdp_rr_sync: RTL
================

// Module: cdp_rr_sync
//
// PURPOSE
//   Parametrised synchronous priority encoder/arbiter, successor of the 4-bit sync priority encoder.
//   N request lines are encoded to the index of the winning line, with a registered output and a
//   valid/ready handshake. Priority is fixed (MSB wins) or round-robin, selected at run time.
//   Sits between request sources and a single consumer, e.g. a shared-resource grant path.
//
// PARAMETERS
//   N      8           number of request lines, N >= 2, need not be a power of two
//   OUT_W  $clog2(N)   width of out; derived, must not be overridden
//
// PORTS
//   clk    in   1      clock, all logic on rising edge
//   rst    in   1      reset, synchronous, active-high
//   in     in   N      request vector; position k (0..N-1) is in[N-1-k], so position 0 = MSB
//   mode   in   1      0 = fixed priority (position 0 highest), 1 = round-robin
//   ready  in   1      consumer accepts the current result when valid && ready
//   out    out  OUT_W  position of the winning request
//   valid  out  1      out holds a real grant
//
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): out=0, valid=0, internal pointer ptr=0; overrides every other input.
//   - Capture condition: cap = !valid || ready. If cap=0 (stall), out and valid hold and in is ignored.
//   - On cap=1, in is sampled at that edge; result appears the next cycle (latency 1 cycle):
//       * in == 0  -> valid<=0, out<=0
//       * else     -> valid<=1, out<=first set position found searching upward from start, modulo N
//   - Search start:
//       * mode=0: start = 0, so this matches the legacy encoder (MSB -> 0)
//       * mode=1: start = (valid && ready) ? (out+1 mod N) : ptr
//   - Pointer: on valid && ready with mode=1, ptr <= (out+1) mod N. Otherwise ptr holds,
//     including all cycles in mode=0.
//   - Wrap: (N-1)+1 wraps to 0. out is never >= N, even when N is not a power of two.
//   - Simultaneous accept and capture: the accepted grant updates ptr and seeds the new search
//     in the same cycle, so a continuous stream has no bubbles.
//   - A mode change takes effect at the next capture. It never alters a result already held.
//   - A request that drops while its grant is stalled still completes; out is not revoked.
//   - Reset mid-stream discards the held result and clears ptr.
//   - No combinational path from in or ready to out or valid.
//
// TESTING
//   1. Reset: N=8, rst=1 for 2 cycles with in=8'hFF, ready=1 -> valid=0, out=0 during and after reset.
//   2. Fixed: mode=0, ready=1, in=8'b0010_0100 -> next cycle valid=1, out=2;
//      then in=0 -> next cycle valid=0, out=0.
//   3. Stall: valid=1, out=2, ready=0; in changes to 8'h80 for 3 cycles -> out stays 2;
//      ready=1 -> the following cycle out=0.
//   4. Round-robin: mode=1, ready=1, in=8'b1000_0001 held -> out sequence 0,7,0,7 with valid=1
//      every cycle.
//   5. Wrap, N=5: mode=1, ready=1, in=5'b11111 -> out 0,1,2,3,4,0,1; never 5..7.
//   6. Reset mid-operation: mode=1, in all ones, after out=3 assert rst for 1 cycle ->
//      valid=0; after release the next grant is out=0 (ptr cleared).

Source files
------------

// File: rtl/cdp_rr_sync.sv
// rtl/cdp_rr_sync.sv - registered N-way priority encoder/arbiter, fixed or round-robin, valid/ready output
module cdp_rr_sync #(
  parameter  int N     = 8,
  localparam int OUT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic             mode,
  input  logic             ready,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  localparam logic [OUT_W-1:0] LAST = OUT_W'(N - 1);

  logic             cap;
  logic             accept;
  logic [N-1:0]     req;
  logic [OUT_W-1:0] ptr;
  logic [OUT_W-1:0] out_inc;
  logic [OUT_W-1:0] start;
  logic [OUT_W-1:0] win;
  logic [OUT_W-1:0] idx;
  logic             any;

  assign cap     = !valid || ready;
  assign accept  = valid && ready;
  assign out_inc = (out == LAST) ? '0 : out + 1'b1;

  // The grant being accepted this edge seeds the next search, so a stream has no bubbles.
  assign start   = mode ? (accept ? out_inc : ptr) : '0;

  // Position k is bit N-1-k, so position 0 is the MSB.
  always_comb begin
    req = '0;
    for (int k = 0; k < N; k++) begin
      req[k] = in[N-1-k];
    end
  end

  // Circular search upward from start; the explicit wrap keeps idx below N for any N.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = start;
    for (int i = 0; i < N; i++) begin
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else begin
      if (accept && mode) begin
        ptr <= out_inc;
      end
      if (cap) begin
        valid <= any;
        out   <= any ? win : '0;
      end
    end
  end

endmodule
